// File: rtl/in_cpld_if.sv
// Host serial link of the interlock command receiver: 3-wire command input plus readback data.
interface in_cpld_if;
    logic sclk;
    logic sdi;
    logic cs_n;
    logic sdo;

    modport master (output sclk, output sdi, output cs_n, input sdo);
    modport slave  (input sclk, input sdi, input cs_n, output sdo);
endinterface

// File: rtl/in_cpld.sv
// Host command receiver for the 8x8 interlock matrix: deserialises 40-bit frames and applies legal ones atomically.
// Optional readback shifter on sdo is built when IN_CPLD_READBACK_EN is defined.
module in_cpld #(
    parameter int SCLK_SYNC = 2
) (
    input  logic        pclk_50M,
    input  logic        prst_n,
    in_cpld_if.slave    host,
    output logic [1:8]  outP,
    output logic [1:28] out,
    output logic        frame_ok,
    output logic [1:0]  err_code,
    output logic [7:0]  rej_cnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CHECK = 2'd2, APPLY = 2'd3} state_t;

    function automatic logic [3:0] frame_csum(input logic [35:0] pl);
        logic [3:0] c;
        c = 4'h0;
        for (int n = 0; n < 9; n++) begin
            c = c ^ pl[35-4*n -: 4];
        end
        return c;
    endfunction

    // A set pair needs both ports enabled, and no port may appear in two set pairs.
    function automatic logic interlock_bad(input logic [1:8] p, input logic [1:28] o);
        logic [1:8] used;
        logic       bad;
        int         k;
        used = 8'h00;
        bad  = 1'b0;
        for (int j = 2; j <= 8; j++) begin
            for (int i = 1; i < j; i++) begin
                k       = (j - 1) * (j - 2) / 2 + i;
                bad     = bad | (o[k] & (~p[i] | ~p[j] | used[i] | used[j]));
                used[i] = used[i] | o[k];
                used[j] = used[j] | o[k];
            end
        end
        return bad;
    endfunction

    logic [SCLK_SYNC-1:0] sclk_sync_r;
    logic [SCLK_SYNC-1:0] sdi_sync_r;
    logic [SCLK_SYNC-1:0] cs_sync_r;
    logic                 sclk_d_r;
    logic                 cs_d_r;
    logic                 sclk_s;
    logic                 sdi_s;
    logic                 cs_s;
    logic                 sclk_rise_s;
    logic                 cs_fall_s;
    logic                 cs_rise_s;

    state_t               state_r;
    logic [5:0]           bit_cnt_r;
    logic [39:0]          shreg_r;
    logic [1:8]           pl_ports_s;
    logic [1:28]          pl_pairs_s;
    logic [1:0]           check_err_s;

    // Synchronise host pins; one extra stage on sclk and cs_n for edge detection
    always_ff @(posedge pclk_50M or negedge prst_n) begin
        if (!prst_n) begin
            sclk_sync_r <= {SCLK_SYNC{1'b0}};
            sdi_sync_r  <= {SCLK_SYNC{1'b0}};
            cs_sync_r   <= {SCLK_SYNC{1'b0}};
            sclk_d_r    <= 1'b0;
            cs_d_r      <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SCLK_SYNC-2:0], host.sclk};
            sdi_sync_r  <= {sdi_sync_r[SCLK_SYNC-2:0], host.sdi};
            cs_sync_r   <= {cs_sync_r[SCLK_SYNC-2:0], host.cs_n};
            sclk_d_r    <= sclk_s;
            cs_d_r      <= cs_s;
        end
    end

    assign sclk_s      = sclk_sync_r[SCLK_SYNC-1];
    assign sdi_s       = sdi_sync_r[SCLK_SYNC-1];
    assign cs_s        = cs_sync_r[SCLK_SYNC-1];
    assign sclk_rise_s = sclk_s & ~sclk_d_r;
    assign cs_fall_s   = ~cs_s & cs_d_r;
    assign cs_rise_s   = cs_s & ~cs_d_r;

    assign pl_ports_s  = shreg_r[39:32];
    assign pl_pairs_s  = shreg_r[31:4];

    // Frame verdict in priority order: length, checksum, interlock
    always_comb begin
        check_err_s = 2'd0;
        if (bit_cnt_r != 6'd40) begin
            check_err_s = 2'd1;
        end else if (frame_csum(shreg_r[39:4]) != shreg_r[3:0]) begin
            check_err_s = 2'd2;
        end else if (interlock_bad(pl_ports_s, pl_pairs_s)) begin
            check_err_s = 2'd3;
        end else begin
            check_err_s = 2'd0;
        end
    end

    // Frame FSM with registered request vectors and status
    always_ff @(posedge pclk_50M or negedge prst_n) begin
        if (!prst_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= 6'd0;
            shreg_r   <= 40'h0;
            outP      <= 8'h00;
            out       <= 28'h0000000;
            frame_ok  <= 1'b0;
            err_code  <= 2'd0;
            rej_cnt   <= 8'd0;
        end else begin
            frame_ok <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (cs_fall_s) begin
                        state_r   <= SHIFT;
                        bit_cnt_r <= 6'd0;
                    end
                end
                SHIFT: begin
                    // A bit arriving together with the cs_n rise still belongs to this frame
                    if (sclk_rise_s) begin
                        shreg_r <= {shreg_r[38:0], sdi_s};
                        if (bit_cnt_r != 6'd41) begin
                            bit_cnt_r <= bit_cnt_r + 6'd1;
                        end
                    end
                    if (cs_rise_s) begin
                        state_r <= CHECK;
                    end
                end
                CHECK: begin
                    if (check_err_s != 2'd0) begin
                        err_code <= check_err_s;
                        if (rej_cnt != 8'hFF) begin
                            rej_cnt <= rej_cnt + 8'd1;
                        end
                        state_r <= IDLE;
                    end else begin
                        state_r <= APPLY;
                    end
                end
                APPLY: begin
                    outP     <= pl_ports_s;
                    out      <= pl_pairs_s;
                    err_code <= 2'd0;
                    frame_ok <= 1'b1;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef IN_CPLD_READBACK_EN
    logic        sclk_fall_s;
    logic [39:0] rb_frame_s;
    logic [38:0] rb_r;
    logic [5:0]  rb_cnt_r;
    logic        sdo_r;

    assign sclk_fall_s = ~sclk_s & sclk_d_r;
    assign rb_frame_s  = {outP, out, frame_csum({outP, out})};

    // Readback shifter: snapshot the applied vectors at frame start, one bit per sclk fall
    always_ff @(posedge pclk_50M or negedge prst_n) begin
        if (!prst_n) begin
            rb_r     <= 39'h0;
            rb_cnt_r <= 6'd40;
            sdo_r    <= 1'b0;
        end else if (cs_fall_s) begin
            sdo_r    <= rb_frame_s[39];
            rb_r     <= rb_frame_s[38:0];
            rb_cnt_r <= 6'd1;
        end else if (sclk_fall_s) begin
            if (rb_cnt_r < 6'd40) begin
                sdo_r    <= rb_r[38];
                rb_r     <= {rb_r[37:0], 1'b0};
                rb_cnt_r <= rb_cnt_r + 6'd1;
            end else begin
                sdo_r <= 1'b0;
            end
        end
    end

    assign host.sdo = sdo_r;
`else
    assign host.sdo = 1'b0;
`endif

endmodule

// File: tb/tb_in_cpld.sv
// Self-checking bench for in_cpld: table-driven frames through a scoreboard plus latency, reset and readback sequences.
module tb_in_cpld;
    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:8]  outP;
    logic [1:28] out;
    logic        frame_ok;
    logic [1:0]  err_code;
    logic [7:0]  rej_cnt;

    in_cpld_if bus ();

    in_cpld #(.SCLK_SYNC(SYNC)) dut (
        .pclk_50M (clk),
        .prst_n   (rst_n),
        .host     (bus),
        .outP     (outP),
        .out      (out),
        .frame_ok (frame_ok),
        .err_code (err_code),
        .rej_cnt  (rej_cnt)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [39:0] frame;
        int          nbits;
        logic [1:8]  e_p;
        logic [1:28] e_o;
        logic [1:0]  e_err;
        logic [7:0]  e_rej;
        int          e_ok;
    } vec_t;

    int          checks    = 0;
    int          failures  = 0;
    int          ok_pulses = 0;
    logic [39:0] rb_cap;
    vec_t        vecs[12];
    vec_t        sb_q[$];

    always @(negedge clk) begin
        if (frame_ok === 1'b1) ok_pulses++;
    end

    initial begin
        #1200000;
        $display("FAIL watchdog: simulation time limit expired, expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference checksum: payload bit k toggles checksum bit 3-(k mod 4)
    function automatic logic [39:0] mk_frame(input logic [1:8] p, input logic [1:28] o);
        logic [35:0] pl;
        logic [3:0]  c;
        pl = {p, o};
        c  = 4'h0;
        for (int k = 0; k < 36; k++) begin
            if (pl[35-k]) c[3-(k%4)] = ~c[3-(k%4)];
        end
        return {pl, c};
    endfunction

    function automatic logic [1:28] pairs(input int k1, input int k2, input int k3, input int k4);
        logic [1:28] o;
        o = 28'h0;
        if (k1 > 0) o[k1] = 1'b1;
        if (k2 > 0) o[k2] = 1'b1;
        if (k3 > 0) o[k3] = 1'b1;
        if (k4 > 0) o[k4] = 1'b1;
        return o;
    endfunction

    task automatic clock_bit(input logic b);
        bus.sdi = b;
        repeat (5) @(negedge clk);
        rb_cap = {rb_cap[38:0], bus.sdo};
        bus.sclk = 1'b1;
        repeat (5) @(negedge clk);
        bus.sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [39:0] f, input int nbits, input bit raise_cs, input bit simul);
        logic b;
        @(negedge clk);
        rb_cap   = 40'h0;
        bus.cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            b = (i < 40) ? f[39-i] : 1'b0;
            if (simul && (i == nbits - 1)) begin
                bus.sdi = b;
                repeat (5) @(negedge clk);
                bus.sclk = 1'b1;
                bus.cs_n = 1'b1;
                repeat (5) @(negedge clk);
                bus.sclk = 1'b0;
            end else begin
                clock_bit(b);
            end
        end
        if (raise_cs && !simul) begin
            repeat (5) @(negedge clk);
            bus.cs_n = 1'b1;
        end
    endtask

    task automatic run_vec(input vec_t v, input bit simul, input string tag);
        vec_t e;
        int   p0;
        sb_q.push_back(v);
        p0 = ok_pulses;
        send_frame(v.frame, v.nbits, 1'b1, simul);
        repeat (12) @(negedge clk);
        e = sb_q.pop_front();
        chk({tag, "_outP"}, 64'(outP), 64'(e.e_p));
        chk({tag, "_out"}, 64'(out), 64'(e.e_o));
        chk({tag, "_err"}, 64'(err_code), 64'(e.e_err));
        chk({tag, "_rej"}, 64'(rej_cnt), 64'(e.e_rej));
        chk({tag, "_okpulses"}, 64'(ok_pulses - p0), 64'(e.e_ok));
    endtask

    initial begin
        logic [39:0] fa, fb, fi1, fi2, fz, fc, fi3, ff, fg, exp_rb;
        logic [1:28] oa, ob, oc, oi1, oi2, oi3, of_, og;
        vec_t        vg, vc;
        int          p0;

        oa  = pairs(1, 0, 0, 0);
        ob  = pairs(6, 15, 0, 0);
        oc  = pairs(1, 6, 15, 28);
        oi1 = pairs(1, 2, 0, 0);
        oi2 = pairs(3, 0, 0, 0);
        oi3 = pairs(1, 3, 0, 0);
        of_ = pairs(28, 0, 0, 0);
        og  = pairs(3, 0, 0, 0);
        fa  = mk_frame(8'b1100_0000, oa);
        fb  = mk_frame(8'b0011_1100, ob);
        fi1 = mk_frame(8'b1110_0000, oi1);
        fi2 = mk_frame(8'b1100_0000, oi2);
        fz  = mk_frame(8'b0000_0000, 28'h0);
        fc  = mk_frame(8'b1111_1111, oc);
        fi3 = mk_frame(8'b1111_1111, oi3);
        ff  = mk_frame(8'b0000_0011, of_);
        fg  = mk_frame(8'b0110_0000, og);

        vecs[0]  = '{fa,          40, 8'b1100_0000, oa,    2'd0, 8'd0, 1};
        vecs[1]  = '{fb,          39, 8'b1100_0000, oa,    2'd1, 8'd1, 0};
        vecs[2]  = '{fb ^ 40'h1,  40, 8'b1100_0000, oa,    2'd2, 8'd2, 0};
        vecs[3]  = '{fb,          40, 8'b0011_1100, ob,    2'd0, 8'd2, 1};
        vecs[4]  = '{fi1,         40, 8'b0011_1100, ob,    2'd3, 8'd3, 0};
        vecs[5]  = '{fi2,         40, 8'b0011_1100, ob,    2'd3, 8'd4, 0};
        vecs[6]  = '{fb,          41, 8'b0011_1100, ob,    2'd1, 8'd5, 0};
        vecs[7]  = '{fz,          40, 8'b0000_0000, 28'h0, 2'd0, 8'd5, 1};
        vecs[8]  = '{fc,          40, 8'b1111_1111, oc,    2'd0, 8'd5, 1};
        vecs[9]  = '{fi3,         40, 8'b1111_1111, oc,    2'd3, 8'd6, 0};
        vecs[10] = '{fi1 ^ 40'h1, 40, 8'b1111_1111, oc,    2'd2, 8'd7, 0};
        vecs[11] = '{fi1 ^ 40'h1, 39, 8'b1111_1111, oc,    2'd1, 8'd8, 0};

        rst_n    = 1'b0;
        bus.sclk = 1'b0;
        bus.sdi  = 1'b0;
        bus.cs_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_outP", 64'(outP), 64'h0);
        chk("rst_out", 64'(out), 64'h0);
        chk("rst_frame_ok", 64'(frame_ok), 64'h0);
        chk("rst_err", 64'(err_code), 64'h0);
        chk("rst_rej", 64'(rej_cnt), 64'h0);
        chk("rst_sdo", 64'(bus.sdo), 64'h0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        for (int v = 0; v < 12; v++) begin
            run_vec(vecs[v], 1'b0, $sformatf("vec%0d", v));
        end

        // Apply latency: outputs and frame_ok appear on the 5th edge after cs_n is driven high
        send_frame(ff, 40, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        bus.cs_n = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 4) begin
                chk("lat_ok_early", 64'(frame_ok), 64'h0);
                chk("lat_outP_early", 64'(outP), 64'hFF);
            end
            if (n == 5) begin
                chk("lat_ok", 64'(frame_ok), 64'h1);
                chk("lat_outP", 64'(outP), 64'h03);
                chk("lat_out", 64'(out), 64'(of_));
                chk("lat_err", 64'(err_code), 64'h0);
            end
            if (n == 6) chk("lat_ok_single", 64'(frame_ok), 64'h0);
        end
        repeat (8) @(negedge clk);

        // Reject latency: err_code and rej_cnt move on the 4th edge
        send_frame(ff ^ 40'h1, 40, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        bus.cs_n = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (n == 3) chk("rej_lat_err_early", 64'(err_code), 64'h0);
            if (n == 4) begin
                chk("rej_lat_err", 64'(err_code), 64'h2);
                chk("rej_lat_rej", 64'(rej_cnt), 64'd9);
            end
        end
        repeat (8) @(negedge clk);

        // 40th sclk rise and cs_n rise in the same cycle
        vg = '{fg, 40, 8'b0110_0000, og, 2'd0, 8'd9, 1};
        run_vec(vg, 1'b1, "simul");

        // Reset in mid-frame, then the tail of the frame must be ignored
        @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 20; i++) clock_bit(fc[39-i]);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outP", 64'(outP), 64'h0);
        chk("mid_rst_out", 64'(out), 64'h0);
        chk("mid_rst_rej", 64'(rej_cnt), 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        p0 = ok_pulses;
        for (int i = 20; i < 40; i++) clock_bit(fc[39-i]);
        repeat (5) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_okpulses", 64'(ok_pulses - p0), 64'h0);
        chk("post_rst_err", 64'(err_code), 64'h0);
        chk("post_rst_rej", 64'(rej_cnt), 64'h0);
        chk("post_rst_outP", 64'(outP), 64'h0);
        vc = '{fc, 40, 8'b1111_1111, oc, 2'd0, 8'd0, 1};
        run_vec(vc, 1'b0, "after_rst");

        // 300 empty frames saturate the reject counter
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            bus.cs_n = 1'b0;
            repeat (4) @(negedge clk);
            bus.cs_n = 1'b1;
            repeat (10) @(negedge clk);
            if (n == 254) chk("sat_rej_254", 64'(rej_cnt), 64'd254);
            if (n == 255) chk("sat_rej_255", 64'(rej_cnt), 64'd255);
        end
        chk("sat_rej_300", 64'(rej_cnt), 64'd255);
        chk("sat_err", 64'(err_code), 64'h1);
        chk("sat_outP", 64'(outP), 64'hFF);
        chk("sat_out", 64'(out), 64'(oc));

        // Readback stream during the next frame equals the last applied frame
        p0 = ok_pulses;
        send_frame(fa, 40, 1'b1, 1'b0);
        repeat (12) @(negedge clk);
`ifdef IN_CPLD_READBACK_EN
        exp_rb = fc;
`else
        exp_rb = 40'h0;
`endif
        chk("readback_stream", 64'(rb_cap), 64'(exp_rb));
        chk("readback_sdo_idle", 64'(bus.sdo), 64'h0);
        chk("readback_outP", 64'(outP), 64'hC0);
        chk("readback_okpulses", 64'(ok_pulses - p0), 64'h1);
        chk("readback_rej", 64'(rej_cnt), 64'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
